hazard_stall_ctrl: RTL

- Pipeline sequencing controller for the 5-stage MIPS core.
- Decides each cycle whether PC and IF/ID advance, hold, or flush, and whether ID/EX takes a bubble.
- Owns occupancy of the multi-cycle MULT/DIV unit next to the EX ALU. Stalls issue of a new MULT/DIV and of HI/LO reads while that unit is busy.
- Complements the EX forwarding unit: it covers only the hazards forwarding cannot resolve, namely load-use, taken branch, and MDU busy.

---
 rtl/hazard_stall_ctrl_pkg.sv | 16 +
 rtl/hazard_stall_ctrl_mdu_occupancy.sv | 57 +++++
 rtl/hazard_stall_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller and the MDU datapath.
package hazard_stall_ctrl_pkg;

    localparam int unsigned REG_W        = 5;
    localparam int unsigned MULT_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF  = 32;
    localparam int unsigned CNT_W_DEF    = 6;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/hazard_stall_ctrl_mdu_occupancy.sv
// MULT/DIV unit occupancy tracker: busy for exactly LAT cycles after a start pulse, done in the last one.
module mdu_occupancy
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic is_div,
    output logic busy,
    output logic done
);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and remaining-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter holds cycles left after the current one, so zero marks the final busy cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = BUSY;
                    cnt_d   = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing control: load-use / MDU-busy stalls, taken-branch flushes, MDU issue.
// Optional HAZARD_STALL_PERF_EN adds stall_cnt and flush_cnt performance counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_uses_src2,
    input  logic             id_mdu_start,
    input  logic             id_mdu_is_div,
    input  logic             id_reads_hilo,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_mem_r_en,
    input  logic             ex_branch_taken,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mdu_go,
    output logic             mdu_busy,
    output logic             mdu_done
`ifdef HAZARD_STALL_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    logic load_use;
    logic mdu_stall;

    assign load_use = ex_mem_r_en && (ex_dest != REG_ZERO) &&
                      ((ex_dest == id_src1) || (id_uses_src2 && (ex_dest == id_src2)));
    assign mdu_stall = mdu_busy && (id_mdu_start || id_reads_hilo);

    // A taken branch squashes the ID instruction, so its hazards and MDU request are moot
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        mdu_go      = id_mdu_start && !mdu_busy && !ex_branch_taken && !load_use;
        if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use || mdu_stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    mdu_occupancy #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_mdu_occupancy (
        .clk    (clk),
        .rst    (rst),
        .go     (mdu_go),
        .is_div (id_mdu_is_div),
        .busy   (mdu_busy),
        .done   (mdu_done)
    );

`ifdef HAZARD_STALL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en)          stall_cnt <= stall_cnt + 32'd1;
            if (ex_branch_taken) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule
